// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the MIPS control pipeline: ALU op codes, field widths
// and the per-stage control-word layouts.
package cpu_ctrl_pkg;

    localparam int ALU_OP_W   = 2;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 2'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 2'd1;
    localparam logic [ALU_OP_W-1:0] ALU_R_TYPE = 2'd2;

    // jump acts entirely in ID, so it is not carried past the ID/EX boundary
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                reg_dst;
        logic                alu_src;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                mem_2_reg;
        logic                reg_write;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_2_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic mem_2_reg;
        logic reg_write;
    } mem_wb_ctrl_t;

    localparam id_ex_ctrl_t BUBBLE = '{alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/control_pipeline_if.sv
// Decoder/datapath-facing bundle of the control pipeline: ID control word in,
// staged control and PC/IF-ID steering out.
interface control_pipeline_if
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                  id_valid;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic                  id_reg_dst;
    logic                  id_alu_src;
    logic                  id_branch;
    logic                  id_jump;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_2_reg;
    logic                  id_reg_write;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  ex_zero;

    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic                  ex_reg_dst;
    logic                  ex_alu_src;
    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic                  wb_mem_2_reg;
    logic                  wb_reg_write;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_flush;
    logic                  pc_src;
    logic                  jump_take;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_alu_op, id_reg_dst, id_alu_src, id_branch, id_jump,
               id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write,
               id_rs, id_rt, ex_zero,
        input  ex_alu_op, ex_reg_dst, ex_alu_src, mem_mem_read, mem_mem_write,
               wb_mem_2_reg, wb_reg_write, pc_write, if_id_write, if_flush,
               pc_src, jump_take, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_alu_op, id_reg_dst, id_alu_src, id_branch, id_jump,
               id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write,
               id_rs, id_rt, ex_zero,
        output ex_alu_op, ex_reg_dst, ex_alu_src, mem_mem_read, mem_mem_write,
               wb_mem_2_reg, wb_reg_write, pc_write, if_id_write, if_flush,
               pc_src, jump_take, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard unit: load-use stall request, branch resolution and
// jump steering for the instruction currently in ID.
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic                  ex_branch,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_zero,
    input  logic                  id_valid,
    input  logic                  id_jump,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    output logic                  stall,
    output logic                  pc_src,
    output logic                  jump_take
);

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign stall = ex_mem_read & id_valid & (ex_rt != '0)
                 & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign pc_src    = ex_branch & ex_zero;
    assign jump_take = id_valid & id_jump & ~stall & ~pc_src;

endmodule

// File: rtl/control_pipeline.sv
// Control path of the 5-stage MIPS core: stages the decoded control word through
// ID/EX, EX/MEM and MEM/WB, inserts bubbles and counts stall/flush events.
module control_pipeline
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    control_pipeline_if.slave bus
);

    id_ex_ctrl_t           id_ex_q;
    id_ex_ctrl_t           id_ex_d;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_rt_d;
    ex_mem_ctrl_t          ex_mem_q;
    mem_wb_ctrl_t          mem_wb_q;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      flush_cnt_q;

    logic stall;
    logic pc_src;
    logic jump_take;
    logic stall_eff;
    logic if_flush;

    hazard_detect u_hazard_detect (
        .ex_mem_read (id_ex_q.mem_read),
        .ex_branch   (id_ex_q.branch),
        .ex_rt       (ex_rt_q),
        .ex_zero     (bus.ex_zero),
        .id_valid    (bus.id_valid),
        .id_jump     (bus.id_jump),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .stall       (stall),
        .pc_src      (pc_src),
        .jump_take   (jump_take)
    );

    // A taken branch squashes the ID instruction anyway, so it overrides the stall
    assign stall_eff = stall & ~pc_src;
    assign if_flush  = pc_src | jump_take;

    always_comb begin
        id_ex_d = BUBBLE;
        ex_rt_d = '0;
        if (!pc_src && !stall && bus.id_valid) begin
            id_ex_d = '{bus.id_alu_op, bus.id_reg_dst, bus.id_alu_src, bus.id_branch,
                        bus.id_mem_read, bus.id_mem_write, bus.id_mem_2_reg,
                        bus.id_reg_write};
            ex_rt_d = bus.id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= BUBBLE;
            ex_rt_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_rt_q  <= ex_rt_d;
            ex_mem_q <= '{id_ex_q.mem_read, id_ex_q.mem_write,
                          id_ex_q.mem_2_reg, id_ex_q.reg_write};
            mem_wb_q <= '{ex_mem_q.mem_2_reg, ex_mem_q.reg_write};
        end
    end

    // Performance counters stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_eff && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (if_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.ex_alu_op     = id_ex_q.alu_op;
    assign bus.ex_reg_dst    = id_ex_q.reg_dst;
    assign bus.ex_alu_src    = id_ex_q.alu_src;
    assign bus.mem_mem_read  = ex_mem_q.mem_read;
    assign bus.mem_mem_write = ex_mem_q.mem_write;
    assign bus.wb_mem_2_reg  = mem_wb_q.mem_2_reg;
    assign bus.wb_reg_write  = mem_wb_q.reg_write;
    assign bus.pc_write      = ~stall_eff;
    assign bus.if_id_write   = ~stall_eff;
    assign bus.if_flush      = if_flush;
    assign bus.pc_src        = pc_src;
    assign bus.jump_take     = jump_take;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule
